// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM controller: state codes, op codes,
// field widths and the power-on contents of the account database.
package atm_pkg;

    localparam int NUM_ACC = 10;
    localparam int PIN_W   = 14;
    localparam int BAL_W   = 32;
    localparam int AMT_W   = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [2:0] {
        ST_ACC_CHK = 3'd0,
        ST_PIN_CHK = 3'd1,
        ST_ERR     = 3'd2,
        ST_BAL     = 3'd3,
        ST_WDR     = 3'd4,
        ST_DEP     = 3'd5,
        ST_CHG     = 3'd6,
        ST_IDLE    = 3'd7
    } state_t;

    localparam logic [2:0] OP_BAL = 3'd3;
    localparam logic [2:0] OP_WDR = 3'd4;
    localparam logic [2:0] OP_DEP = 3'd5;
    localparam logic [2:0] OP_CHG = 3'd6;

    function automatic logic [PIN_W-1:0] init_pin(input int k);
        case (k)
            0:       return 14'd1234;
            1:       return 14'd2345;
            2:       return 14'd3456;
            3:       return 14'd4567;
            4:       return 14'd5678;
            5:       return 14'd6789;
            6:       return 14'd7890;
            7:       return 14'd8901;
            8:       return 14'd9012;
            default: return 14'd7123;
        endcase
    endfunction

    function automatic logic [BAL_W-1:0] init_bal(input int k);
        return BAL_W'(1000 * (k + 1));
    endfunction

endpackage

// File: rtl/atm_account_db.sv
// Account register file: combinational read and synchronous single-port write
// of PIN and balance per entry; reset restores the power-on contents.
module atm_account_db
    import atm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    output logic [PIN_W-1:0] rd_pin,
    output logic [BAL_W-1:0] rd_bal,
    input  logic             pin_we,
    input  logic [PIN_W-1:0] pin_wdata,
    input  logic             bal_we,
    input  logic [BAL_W-1:0] bal_wdata
);

    logic [PIN_W-1:0] pin_mem [NUM_ACC];
    logic [BAL_W-1:0] bal_mem [NUM_ACC];

    // Out-of-range indices read as zero and never write.
    always_comb begin
        rd_pin = '0;
        rd_bal = '0;
        for (int k = 0; k < NUM_ACC; k++) begin
            if (idx == IDX_W'(k)) begin
                rd_pin = pin_mem[k];
                rd_bal = bal_mem[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_ACC; k++) begin
                pin_mem[k] <= init_pin(k);
                bal_mem[k] <= init_bal(k);
            end
        end else begin
            for (int k = 0; k < NUM_ACC; k++) begin
                if (pin_we && idx == IDX_W'(k)) pin_mem[k] <= pin_wdata;
                if (bal_we && idx == IDX_W'(k)) bal_mem[k] <= bal_wdata;
            end
        end
    end

endmodule

// File: rtl/atm_controller.sv
// ATM transaction controller: latches a request in IDLE, checks account and
// PIN, performs one operation against the account database, returns to IDLE.
//
// state       | meaning
// IDLE    (7) | latch request inputs
// ACC_CHK (0) | account number range check
// PIN_CHK (1) | PIN compare, dispatch on operation
// ERR     (2) | invalid operation, one-cycle pause
// BAL     (3) | balance inquiry
// WDR     (4) | withdraw
// DEP     (5) | deposit
// CHG     (6) | change PIN
module atm_controller
    import atm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       operation,
    input  logic [3:0]       acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic [PIN_W-1:0] newPin,
    input  logic [AMT_W-1:0] amount,
    input  logic             language,
    output logic [BAL_W-1:0] balance,
    output logic             success,
    output logic [2:0]       state
);

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [3:0]       acc_q;
    logic [PIN_W-1:0] pin_q, new_pin_q;
    logic [AMT_W-1:0] amt_q;
    logic             lang_q;
    logic             unused_lang;

    logic [BAL_W-1:0] balance_d;
    logic             success_d;
    logic [IDX_W-1:0] idx;
    logic [PIN_W-1:0] rd_pin;
    logic [BAL_W-1:0] rd_bal;
    logic             pin_we, bal_we;
    logic [BAL_W-1:0] bal_wdata;

    logic             acc_ok, pin_ok, wdr_ok, dep_ok, chg_ok;
    logic [BAL_W:0]   dep_sum;
    logic [BAL_W-1:0] wdr_res;

    assign unused_lang = lang_q;
    assign state       = state_q;
    assign idx         = acc_q - 4'd1;

    atm_account_db u_db (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .rd_pin    (rd_pin),
        .rd_bal    (rd_bal),
        .pin_we    (pin_we),
        .pin_wdata (new_pin_q),
        .bal_we    (bal_we),
        .bal_wdata (bal_wdata)
    );

    assign acc_ok  = (acc_q >= 4'd1) && (acc_q <= 4'(NUM_ACC));
    assign pin_ok  = (pin_q == rd_pin);
    assign wdr_ok  = (BAL_W'(amt_q) <= rd_bal);
    assign wdr_res = rd_bal - BAL_W'(amt_q);
    assign dep_sum = {1'b0, rd_bal} + (BAL_W+1)'(amt_q);
    assign dep_ok  = !dep_sum[BAL_W];
    assign chg_ok  = (new_pin_q != rd_pin) && (new_pin_q >= 14'd1000) && (new_pin_q <= 14'd9999);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            balance   <= '0;
            success   <= 1'b0;
            op_q      <= '0;
            acc_q     <= '0;
            pin_q     <= '0;
            new_pin_q <= '0;
            amt_q     <= '0;
            lang_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            balance <= balance_d;
            success <= success_d;
            if (state_q == ST_IDLE) begin
                op_q      <= operation;
                acc_q     <= acc_num;
                pin_q     <= pin;
                new_pin_q <= newPin;
                amt_q     <= amount;
                lang_q    <= language;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        balance_d = balance;
        success_d = success;
        pin_we    = 1'b0;
        bal_we    = 1'b0;
        bal_wdata = wdr_res;
        case (state_q)
            ST_IDLE: state_d = ST_ACC_CHK;
            ST_ACC_CHK: begin
                if (acc_ok) begin
                    state_d = ST_PIN_CHK;
                end else begin
                    success_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_PIN_CHK: begin
                if (!pin_ok) begin
                    success_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    case (op_q)
                        OP_BAL, OP_WDR, OP_DEP, OP_CHG: state_d = state_t'(op_q);
                        default: begin
                            success_d = 1'b0;
                            state_d   = ST_ERR;
                        end
                    endcase
                end
            end
            ST_BAL: begin
                balance_d = rd_bal;
                success_d = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_WDR: begin
                success_d = wdr_ok;
                if (wdr_ok) begin
                    bal_we    = 1'b1;
                    balance_d = wdr_res;
                end
                state_d = ST_IDLE;
            end
            ST_DEP: begin
                bal_wdata = dep_sum[BAL_W-1:0];
                success_d = dep_ok;
                if (dep_ok) begin
                    bal_we    = 1'b1;
                    balance_d = dep_sum[BAL_W-1:0];
                end
                state_d = ST_IDLE;
            end
            ST_CHG: begin
                pin_we    = chg_ok;
                success_d = chg_ok;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_atm_controller.sv
// Scoreboard bench for atm_controller: stimulus queues expectations from a
// behavioural account model; a negedge monitor pops and compares them.
module tb_atm_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  operation = '0;
    logic [3:0]  acc_num = '0;
    logic [13:0] pin = '0;
    logic [13:0] new_pin = '0;
    logic [15:0] amount = '0;
    logic        language = 1'b0;
    logic [31:0] balance;
    logic        success;
    logic [2:0]  state;

    always #5 clk = ~clk;

    atm_controller dut (
        .clk       (clk),
        .rst       (rst),
        .operation (operation),
        .acc_num   (acc_num),
        .pin       (pin),
        .newPin    (new_pin),
        .amount    (amount),
        .language  (language),
        .balance   (balance),
        .success   (success),
        .state     (state)
    );

    localparam int K_BAL = 0;
    localparam int K_SUC = 1;
    localparam int K_ST  = 2;

    typedef struct {
        int     kind;
        longint val;
        int     tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   tag = 0;

    // Reference model: account contents plus the held output registers.
    int     m_pin[10];
    longint m_bal[10];
    longint m_obal;
    int     m_succ;

    always @(negedge clk) begin
        exp_t   e;
        longint act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                K_BAL:   act = longint'(balance);
                K_SUC:   act = longint'(success);
                default: act = longint'(state);
            endcase
            total++;
            if (act != e.val) begin
                bad++;
                $display("FAIL %s txn=%0d: actual=%0d required=%0d",
                         (e.kind == K_BAL) ? "balance" : (e.kind == K_SUC) ? "success" : "state",
                         e.tag, act, e.val);
            end
        end
    end

    task automatic check_now(input string what, input longint act, input longint exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s txn=%0d: actual=%0d required=%0d", what, tag, act, exp_v);
        end
    endtask

    task automatic push(input int kind, input longint val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.tag  = tag;
        q.push_back(e);
    endtask

    task automatic model_reset();
        int pins[10] = '{1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 7123};
        for (int k = 0; k < 10; k++) begin
            m_pin[k] = pins[k];
            m_bal[k] = 1000 * (k + 1);
        end
        m_obal = 0;
        m_succ = 0;
    endtask

    // Applies one request to the model; st4 is the state expected after four edges.
    task automatic model_apply(input int op, input int acc, input int p, input int np,
                               input longint amt, output int st4);
        int k;
        st4 = 7;
        if (acc < 1 || acc > 10) begin
            m_succ = 0;
            return;
        end
        k = acc - 1;
        if (p != m_pin[k]) begin
            m_succ = 0;
            st4 = 0;
            return;
        end
        case (op)
            3: begin m_obal = m_bal[k]; m_succ = 1; end
            4: begin
                if (amt <= m_bal[k]) begin
                    m_bal[k] = m_bal[k] - amt;
                    m_obal = m_bal[k];
                    m_succ = 1;
                end else m_succ = 0;
            end
            5: begin
                if (m_bal[k] + amt < 64'h1_0000_0000) begin
                    m_bal[k] = m_bal[k] + amt;
                    m_obal = m_bal[k];
                    m_succ = 1;
                end else m_succ = 0;
            end
            6: begin
                if (np != m_pin[k] && np >= 1000 && np <= 9999) begin
                    m_pin[k] = np;
                    m_succ = 1;
                end else m_succ = 0;
            end
            default: m_succ = 0;
        endcase
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (state != 3'd7 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check_now("state (idle wait expired)", longint'(state), 7);
        end
    endtask

    task automatic drive(input int op, input int acc, input int p, input int np, input int amt);
        operation = 3'(op);
        acc_num   = 4'(acc);
        pin       = 14'(p);
        new_pin   = 14'(np);
        amount    = 16'(amt);
        language  = 1'($urandom_range(0, 1));
    endtask

    task automatic txn(input int op, input int acc, input int p, input int np, input int amt);
        int st4;
        wait_idle();
        tag++;
        drive(op, acc, p, np, amt);
        model_apply(op, acc, p, np, longint'(amt), st4);
        repeat (4) @(posedge clk);
        #1;
        push(K_BAL, m_obal);
        push(K_SUC, m_succ);
        push(K_ST, st4);
    endtask

    initial begin
        int n;
        int acc, p, op, np, amt;
        model_reset();

        // Reset state
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_now("reset state", longint'(state), 7);
        check_now("reset balance", longint'(balance), 0);
        check_now("reset success", longint'(success), 0);
        @(negedge clk);
        #1;
        rst = 1'b1;

        for (int a = 1; a <= 10; a++) txn(3, a, m_pin[a-1], 0, 0);

        txn(5, 3, 3456, 0, 1000);
        txn(4, 3, 3456, 0, 500);
        txn(4, 3, 3456, 0, 3600);
        txn(3, 3, 3456, 0, 0);

        for (int a = 11; a <= 15; a++) txn(3, a, 1234, 0, 0);
        txn(5, 0, 1234, 0, 7);
        txn(4, 1, 7123, 0, 10);

        txn(4, 2, 2345, 0, 2000);
        txn(3, 2, 2345, 0, 0);

        txn(6, 1, 1234, 1234, 0);
        txn(6, 1, 1234, 5678, 0);
        txn(3, 1, 1234, 0, 0);
        txn(3, 1, 5678, 0, 0);
        txn(6, 4, 4567, 999, 0);
        txn(6, 4, 4567, 10000, 0);
        txn(6, 4, 4567, 1000, 0);
        txn(3, 4, 1000, 0, 0);

        // Invalid operation: fixed state walk, then reset while in PIN_CHK
        txn(5, 5, 5678, 0, 333);
        wait_idle();
        tag++;
        drive(7, 2, m_pin[1], 0, 0);
        @(posedge clk); #1; push(K_ST, 0);
        @(posedge clk); #1; push(K_ST, 1);
        @(posedge clk); #1; push(K_ST, 2);
        @(posedge clk); #1; push(K_ST, 7); push(K_SUC, 0); push(K_BAL, m_obal);
        @(posedge clk); #1; push(K_ST, 0);
        n = 0;
        while (state != 3'd1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 10) check_now("state (PIN_CHK wait expired)", longint'(state), 1);
        tag++;
        rst = 1'b0;
        model_reset();
        #1;
        check_now("mid-txn reset state", longint'(state), 7);
        check_now("mid-txn reset balance", longint'(balance), 0);
        check_now("mid-txn reset success", longint'(success), 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        txn(3, 5, 5678, 0, 0);
        txn(3, 1, 1234, 0, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 200; i++) begin
            acc = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 10)) : int'($urandom_range(0, 15));
            if (acc >= 1 && acc <= 10 && $urandom_range(0, 9) < 8) p = m_pin[acc-1];
            else p = int'($urandom_range(0, 16383));
            op  = ($urandom_range(0, 9) < 9) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 7));
            np  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(900, 10100)) : int'($urandom_range(0, 16383));
            amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 12000));
            txn(op, acc, p, np, amt);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/atm_controller.md
Name: atm_controller

Overview:
- Single-session ATM transaction controller with an internal 10-entry account database holding account number, PIN and balance per entry.
- Per transaction it checks the account, checks the PIN, executes one operation, then returns to idle.
- Operations: balance inquiry, withdraw, deposit, change PIN.
- Sits behind a front-end that holds all request inputs stable for one full 4-cycle transaction window.

Parameters:
- NUM_ACC, 10, number of database entries; valid account numbers are 1..NUM_ACC.
- PIN_W, 14, PIN width.
- BAL_W, 32, balance width.
- AMT_W, 16, transaction amount width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- operation  in  3  requested operation: 3=balance, 4=withdraw, 5=deposit, 6=change PIN; all other values are invalid.
- acc_num  in  4  account number, 1..10.
- pin  in  14  entered PIN.
- newPin  in  14  replacement PIN for operation 6.
- amount  in  16  withdraw/deposit amount, unsigned.
- language  in  1  0=English, 1=alternate; latched per transaction, no datapath effect.
- balance  out  32  balance of the last successfully operated account.
- success  out  1  result of the last completed step.
- state  out  3  current FSM state code.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=7 (IDLE), balance=0, success=0.
  - Database reloads its initial contents.
  - Entry k (k=0..9) holds acc=k+1.
  - PINs: 1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 7123.
  - Balances: 1000·(k+1).
- FSM, all transitions on posedge while rst=1:
  - IDLE(7) -> ACC_CHK(0) unconditionally; latch operation, acc_num, pin, newPin, amount, language.
  - ACC_CHK(0): acc_num in 1..10 -> PIN_CHK(1); else success<=0, -> IDLE.
  - PIN_CHK(1): pin == stored PIN -> state code = operation if operation in 3..6; else success<=0, -> IDLE. Invalid operation -> ERR(2) with success<=0, then ERR -> IDLE next cycle.
  - BAL(3): balance<=stored balance, success<=1, -> IDLE.
  - WDR(4):
    - amount <= stored balance (equality allowed): stored-=amount, balance<=new value, success<=1.
    - else success<=0, stored value and balance output unchanged.
    - -> IDLE.
  - DEP(5):
    - stored + zero-extended amount fits in 32 bits: update stored value, balance<=new value, success<=1.
    - overflow: reject, success<=0.
    - -> IDLE.
  - CHG(6):
    - newPin != stored PIN and newPin in 1000..9999: stored PIN<=newPin, success<=1.
    - else success<=0.
    - balance output unchanged; -> IDLE.
- Timing:
  - A successful transaction completes exactly on the 4th rising edge after IDLE.
  - A failing transaction exits early, restarts from IDLE with the same latched-again inputs, and is idempotent, so results are valid after 4 edges in all cases.
- Outputs balance and success are registered and hold until next written.
- Reset asserted mid-transaction aborts the transaction with no database write.
- Database update and the balance/success update occur on the same edge.

Decomposition:
- Package atm_pkg:
  - state codes: IDLE=7, ACC_CHK=0, PIN_CHK=1, ERR=2, BAL=3, WDR=4, DEP=5, CHG=6.
  - op codes, NUM_ACC, widths, initial PIN/balance constant arrays.
- One sub-module, atm_account_db:
  - synchronous-write, combinational-read register file of PIN and balance per index.
  - single write port for each field; async reset to initial constants.
- Top module: FSM, input latch, compare/arithmetic.

Test Plan:
- rst=0 for one cycle -> state=7, balance=0, success=0 at next negedge.
- Balance inquiry for acc 1..10 with correct PINs, 4 cycles each -> balance=1000·acc, success=1.
- Deposit 1000 then withdraw 500 on acc 3 (pin 3456) -> balance 4000 then 3500; then withdraw 3600 -> success=0, balance stays 3500.
- acc_num=11..15, or acc 1 with pin 7123 -> success=0, no database change.
- Change PIN:
  - acc 1, pin 1234 -> newPin 1234: success=0.
  - acc 1, pin 1234 -> newPin 5678: success=1.
  - balance inquiry with pin 1234: fails; with pin 5678: succeeds.
- operation=7 with valid acc/PIN -> state sequence 7,0,1,2,7 repeating, success=0, database unchanged; rst=0 during state 1 -> immediate state=7.
